// File: rtl/uart_rx_sequencer.sv
// UART receive sequencer: start detect, mid-bit sampling, stop check, FIFO strobe.
// Optional parity stage when UART_RX_PARITY_EN is defined.
module uart_rx_sequencer #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 rx_serial,
    input  logic                 fifo_full,
`ifdef UART_RX_PARITY_EN
    input  logic                 parity_odd,
    output logic                 parity_error,
`endif
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 framing_error,
    output logic                 overrun_error,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t               state, state_n;
    logic [TW-1:0]        tick_cnt, tick_n;
    logic [BW-1:0]        bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shift_reg, shift_n;
    logic                 rx_meta, rx_s;
    logic                 eval;
    logic                 par_bad;
    logic                 valid_n, fe_n, oe_n, pe_n;

`ifdef UART_RX_PARITY_EN
    logic par_bit, par_n;
    assign par_bad = ((^shift_reg) ^ par_bit) != parity_odd;
`else
    assign par_bad = 1'b0;
`endif

    assign busy = (state != IDLE);

    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_cnt;
        shift_n = shift_reg;
        eval    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_n   = par_bit;
`endif
        if (baud_tick) begin
            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_n = START;
                        tick_n  = '0;
                    end
                end
                START: begin
                    if (tick_cnt == T_MID) begin
                        tick_n  = '0;
                        bit_n   = '0;
                        state_n = rx_s ? IDLE : DATA;
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_cnt == T_END) begin
                        tick_n  = '0;
                        shift_n = {rx_s, shift_reg[DATA_BITS-1:1]};
                        bit_n   = bit_cnt + 1'b1;
                        if (bit_cnt == B_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick_cnt == T_END) begin
                        tick_n  = '0;
                        par_n   = rx_s;
                        state_n = STOP;
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    // Leave at mid stop bit so a back-to-back start edge is seen
                    if (tick_cnt == T_END) begin
                        tick_n  = '0;
                        eval    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        valid_n = 1'b0;
        fe_n    = 1'b0;
        oe_n    = 1'b0;
        pe_n    = eval && par_bad;
        if (eval) begin
            priority case (1'b1)
                !rx_s:     fe_n    = 1'b1;
                par_bad:   pe_n    = 1'b1;
                fifo_full: oe_n    = 1'b1;
                default:   valid_n = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta       <= 1'b1;
            rx_s          <= 1'b1;
            state         <= IDLE;
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit       <= 1'b0;
            parity_error  <= 1'b0;
`endif
        end else begin
            rx_meta       <= rx_serial;
            rx_s          <= rx_meta;
            state         <= state_n;
            tick_cnt      <= tick_n;
            bit_cnt       <= bit_n;
            shift_reg     <= shift_n;
            rx_valid      <= valid_n;
            framing_error <= fe_n;
            overrun_error <= oe_n;
            if (valid_n) rx_data <= shift_reg;
`ifdef UART_RX_PARITY_EN
            par_bit       <= par_n;
            parity_error  <= pe_n;
`endif
        end
    end

`ifndef UART_RX_PARITY_EN
    logic unused_pe;
    assign unused_pe = pe_n;
`endif

endmodule

// File: doc/uart_rx_sequencer.md
Name:
uart_rx_sequencer

Overview:
- Controller that sequences the UART receive datapath.
- Detects the start bit on the serial line and times mid-bit sampling from an oversampled baud tick.
- Drives the RX shift register, counts data bits and checks the stop bit.
- Issues a single write strobe toward the RX FIFO; flags framing and overrun errors. Sits between the baud generator and the RX FIFO.

Parameters:
- DATA_BITS, 8, data bits per frame (5..9), LSB first.
- OVERSAMPLE, 16, baud_tick pulses per bit period (even, >=8).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- baud_tick  input  1  one-clk pulse, OVERSAMPLE per bit period
- rx_serial  input  1  asynchronous serial line, idle high
- fifo_full  input  1  RX FIFO full
- rx_data  output  DATA_BITS  received byte, valid when rx_valid=1
- rx_valid  output  1  one-clk write strobe to RX FIFO
- framing_error  output  1  one-clk pulse: stop bit sampled low
- overrun_error  output  1  one-clk pulse: good frame dropped because FIFO full
- busy  output  1  high in any state except IDLE

Behaviour:
- Reset (synchronous, active-high): state=IDLE; tick_cnt=0; bit_cnt=0; shift reg=0; rx_data=0; rx_valid=0; framing_error=0; overrun_error=0; busy=0; synchronizer flops=1. Reset overrides any frame in progress; the partial frame is discarded with no strobe.
- rx_serial passes through a 2-flop synchronizer (rx_s); all decisions use rx_s. This adds 2 clk of latency.
- Counters advance only on clk edges where baud_tick=1. tick_cnt is $clog2(OVERSAMPLE) bits; bit_cnt is $clog2(DATA_BITS+1) bits.
- FSM states:
  - IDLE: rx_s==0 on a baud_tick -> START, tick_cnt=0.
  - START: at tick_cnt==OVERSAMPLE/2-1 (mid start bit), re-sample rx_s. If 0 -> DATA, tick_cnt=0, bit_cnt=0. If 1 -> false start, back to IDLE, no flags.
  - DATA: at tick_cnt==OVERSAMPLE-1, shift rx_s into the MSB of the shift reg (right shift, LSB first) and increment bit_cnt. After the DATA_BITS-th sample -> STOP, tick_cnt=0.
  - STOP: at tick_cnt==OVERSAMPLE-1, sample rx_s, then -> IDLE the same cycle. Returning at mid stop bit allows back-to-back frames.
- Stop-bit outcome (outputs registered; pulse in the clk cycle after the sampling baud_tick):
  - rx_s==1 and fifo_full==0: rx_valid=1; rx_data=shift reg.
  - rx_s==1 and fifo_full==1: overrun_error=1; rx_valid=0.
  - rx_s==0: framing_error=1; rx_valid=0, regardless of fifo_full.
- rx_data holds its last value between strobes.
- fifo_full is sampled only at stop evaluation; changes during the frame are ignored.
- At most one of rx_valid, framing_error, overrun_error is asserted per frame.
- A line held low after a framing error is seen in IDLE as a new start bit and is treated normally.
- baud_tick absent: FSM holds state indefinitely.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - Adds state PARITY between DATA and STOP, sampled at tick_cnt==OVERSAMPLE-1.
  - Adds input parity_odd (1=odd parity, 0=even parity) and output parity_error (one-clk pulse).
  - A parity mismatch blocks rx_valid and asserts parity_error together with the stop outcome.
  - If parity and stop are both bad, parity_error and framing_error pulse together.
- When undefined: no PARITY state, no parity ports; the frame is exactly 1 start + DATA_BITS + 1 stop.

Test Plan:
- Frame 0xA5, OVERSAMPLE=16, fifo_full=0 -> exactly one rx_valid pulse, rx_data=0xA5, no error flags, busy low after stop.
- rx_serial low for 4 ticks, then high -> START aborts to IDLE; no rx_valid, no flags.
- Frame 0x3C with stop bit forced low -> framing_error one pulse, rx_valid stays 0.
- Frame 0x7E with fifo_full=1 at stop -> overrun_error one pulse, rx_valid stays 0, rx_data unchanged.
- Back-to-back 0x00 then 0xFF, no idle gap -> two rx_valid pulses, data 0x00 then 0xFF.
- reset asserted mid DATA (bit 3), then frame 0x5A -> outputs return to reset values the next clk; rx_data=0x5A on the following strobe.
- With UART_RX_PARITY_EN, parity_odd=0, frame 0x01 sent with parity bit 0 -> parity_error pulse, no rx_valid.
